// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage plus a carry flop, LSB first.
// Optional signed-overflow flag is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [RW-1:0]    res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic bit_sum;
    logic bit_carry;
    logic last_bit;

    assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_carry = ((a_sr[0] ^ b_sr[0]) & carry) | (a_sr[0] & b_sr[0]);
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // The result register only needs WIDTH-1 bits: the MSB comes straight
    // from the adder on the final edge when sum is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sr <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_carry;
                    res_sr <= (res_sr >> 1) | (RW'(bit_sum) << (RW - 1));
                    if (last_bit) begin
                        sum   <= {bit_sum, res_sr};
                        cout  <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf   <= carry ^ bit_carry;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner
// sequences and randomized operations against an arithmetic reference model.
module tb_serial_adder;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain unsigned and two's-complement arithmetic.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic c);
        int sx, sy, total;
        sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        total = sx + sy + int'(c);
        return OVF_EN && ((total > (1 << (WIDTH-1)) - 1) || (total < -(1 << (WIDTH-1))));
    endfunction

    task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic cv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        check_output("busy_after_start", busy, 1'b1);
    endtask

    // Starts an add and waits for done; returns at #1 after the done edge.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input string tag);
        int cycles;
        logic [WIDTH:0] expv;
        expv = model_add(av, bv, cv);
        apply_stimulus(av, bv, cv);
        cycles = 0;
        while (done !== 1'b1 && cycles < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_output({tag, "_latency"}, cycles, WIDTH);
        check_output({tag, "_done"}, done, 1'b1);
        check_output({tag, "_busy_at_done"}, busy, 1'b0);
        check_output({tag, "_sum"}, sum, expv[WIDTH-1:0]);
        check_output({tag, "_cout"}, cout, expv[WIDTH]);
        check_output({tag, "_ovf"}, ovf, model_ovf(av, bv, cv));
    endtask

    task automatic check_idle_after(input logic [WIDTH-1:0] held_sum, input string tag);
        @(posedge clk);
        #1;
        check_output({tag, "_done_pulse_end"}, done, 1'b0);
        check_output({tag, "_idle_busy"}, busy, 1'b0);
        check_output({tag, "_sum_held"}, sum, held_sum);
    endtask

    initial begin
        vec_t vecs[$];
        int   pulses;

        vecs.push_back('{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_done", done, 1'b0);
        check_output("reset_sum", sum, 8'h00);
        check_output("reset_cout", cout, 1'b0);
        check_output("reset_ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("idle_no_start_busy", busy, 1'b0);

        // Table vectors with hand-computed expectations
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_tbl_sum", i), sum, vecs[i].exp_sum);
            check_output($sformatf("vec%0d_tbl_cout", i), cout, vecs[i].exp_cout);
            check_output($sformatf("vec%0d_tbl_ovf", i), ovf, OVF_EN ? vecs[i].exp_ovf : 1'b0);
            check_idle_after(vecs[i].exp_sum, $sformatf("vec%0d", i));
        end

        // Back-to-back: second start issued during the DONE cycle
        run_op(8'hFF, 8'h00, 1'b1, "b2b_first");
        run_op(8'h12, 8'h34, 1'b1, "b2b_second");
        check_output("b2b_second_sum_const", sum, 8'h47);
        check_idle_after(8'h47, "b2b");

        // Start while busy must be ignored
        apply_stimulus(8'h01, 8'h01, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3 * WIDTH; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_output("busy_ignore_pulses", pulses, 1);
        check_output("busy_ignore_sum", sum, 8'h02);
        check_output("busy_ignore_cout", cout, 1'b0);

        // Reset during RUN cycle 4 aborts with no done pulse
        apply_stimulus(8'hF0, 8'hF0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", busy, 1'b0);
        check_output("midrst_done", done, 1'b0);
        check_output("midrst_sum", sum, 8'h00);
        check_output("midrst_cout", cout, 1'b0);
        check_output("midrst_ovf", ovf, 1'b0);
        pulses = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check_output("midrst_no_done", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h03, 8'h04, 1'b0, "post_rst");
        check_output("post_rst_sum_const", sum, 8'h07);
        check_idle_after(8'h07, "post_rst");

        // Randomized operations, some back-to-back
        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            logic [WIDTH:0]   rexp;
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom);
            rexp = model_add(ra, rb, rc);
            run_op(ra, rb, rc, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 0) check_idle_after(rexp[WIDTH-1:0], $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder: loads two operands and a carry-in on a start strobe, then resolves one bit per clock, LSB first.
- Each bit uses one full-adder stage (sum = a^b^c, carry = (a^b)&c | a&b) plus a registered carry flip-flop.
- Sits downstream of the operand source and upstream of result consumers.
- Area-cheap alternative to a WIDTH-wide ripple chain; throughput is one add per WIDTH+1 cycles.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled on the rising clk edge
- a  input  WIDTH  operand A; captured on an accepted start
- b  input  WIDTH  operand B; captured on an accepted start
- cin  input  1  carry-in; captured on an accepted start
- busy  output  1  high while bits are being resolved
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result; held between operations
- cout  output  1  registered carry-out; held between operations
- ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand shift registers, carry flop and bit counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → load a, b into shift registers, carry flop←cin, counter←0, go RUN.
  - start=0 → stay in IDLE.
- RUN:
  - busy=1.
  - Each edge computes bit i = counter from a_sr[0], b_sr[0] and the carry flop.
  - The sum bit is shifted into the MSB of the result shift register; operand registers shift right; carry flop←bit carry; counter+1.
  - The edge that processes bit WIDTH-1 (edge E_WIDTH) copies the result shift register and the final carry to sum/cout, and goes to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation, go RUN). Otherwise go IDLE.
- Latency:
  - start edge E0 → busy high after E0.
  - done high in the cycle after E_WIDTH.
  - Start-to-start period: WIDTH+1 cycles.
- start is ignored while in RUN. Operands are not re-sampled and there is no queuing.
- a, b, cin may change freely after the accepting edge.
- sum/cout are updated only on the DONE transition. They hold their previous value during RUN and until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Result is unsigned and exact.
- Reset mid-RUN: operation aborted, all outputs return to reset values, no done pulse.
- Counter width: clog2(WIDTH). The counter never wraps past WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN
- Defined:
  - Carry into the MSB is captured while processing bit WIDTH-1.
  - ovf = carry_into_msb ^ cout, registered together with sum/cout on the DONE transition and held likewise.
  - Reset value 0.
- Undefined: ovf is tied to 0 and no extra flops are built. The port list is identical in both builds.

Test Plan (WIDTH=8):
- Basic add: a=0x0F, b=0x01, cin=0, start at E0 → busy for 8 cycles; done single pulse after E8; sum=0x10, cout=0.
- Carry-out: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; ovf=0 in both builds.
- Carry-in: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x12, b=0x34, cin=1 issued back-to-back during DONE → second done 9 cycles after the first; sum=0x47, cout=0.
- Signed overflow: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0; ovf=1 with SERIAL_ADDER_OVF_EN, 0 without.
- Start while busy: start with 0x01+0x01, then start again with 0xAA+0x55 at E3 → second request ignored; sum=0x02; exactly one done pulse.
- Reset mid-operation: rst_n low during RUN cycle 4 → busy, done, sum, cout, ovf all 0 immediately. A new 0x03+0x04 after release → sum=0x07, cout=0.
